// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite ROM fetch path.
// Sprite base addresses index the 4-bit palette-index ROM, stored row-major.
package sprite_pkg;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned COL_W  = 12;
  localparam int unsigned ROW_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] index;
    logic [COL_W-1:0]  x;
    logic [ROW_W-1:0]  y;
    logic              last;
  } pix_entry_t;

  localparam int unsigned CLOUD_BASE   = 44420;
  localparam int unsigned CLOUD_W      = 92;
  localparam int unsigned CLOUD_H      = 27;
  localparam int unsigned HORIZON_BASE = 85015;
  localparam int unsigned HORIZON_W    = 2400;
  localparam int unsigned HORIZON_H    = 24;
  localparam int unsigned RUN1_BASE    = 191323;
  localparam int unsigned RUN1_W       = 88;
  localparam int unsigned RUN1_H       = 94;
  localparam int unsigned NUM0_BASE    = 168215;
  localparam int unsigned NUM0_W       = 18;
  localparam int unsigned NUM0_H       = 21;

  // Modulo-3 pointer increment for the 3-entry pixel FIFO.
  function automatic logic [1:0] ptr_inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/sprite_fetch_engine_fifo.sv
// pix_fifo3: 3-deep registered FIFO; head is read straight from storage, no fall-through.
// Flush has priority over push/pop; count is exported for the fetch credit check.
module pix_fifo3 #(
  parameter int unsigned W = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         valid,
  output logic [1:0]   count
);
  import sprite_pkg::*;

  logic [W-1:0] mem_q [3];
  logic [1:0]   wr_ptr_q, rd_ptr_q, count_q;
  logic         pop_ok, push_ok;

  always_comb begin
    pop_ok  = pop && (count_q != 2'd0);
    push_ok = push && ((count_q != 2'd3) || pop_ok);
    valid   = (count_q != 2'd0);
    count   = count_q;
    head    = (rd_ptr_q == 2'd2) ? mem_q[2] : (rd_ptr_q == 2'd1) ? mem_q[1] : mem_q[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) mem_q[i] <= '0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 2'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (push_ok && (wr_ptr_q == 2'(i))) mem_q[i] <= push_data;
      end
      if (push_ok) wr_ptr_q <= ptr_inc3(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= ptr_inc3(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && !pop && (count_q == 2'd3)));

endmodule

// File: rtl/sprite_fetch_engine.sv
// Walks a column/row window of a row-major sprite in the palette ROM, one read per cycle,
// and streams tagged pixels through a 3-entry FIFO that absorbs the 1-cycle ROM latency.
module sprite_fetch_engine #(
  parameter int unsigned ADDR_W = sprite_pkg::ADDR_W,
  parameter int unsigned DATA_W = sprite_pkg::DATA_W,
  parameter int unsigned COL_W  = sprite_pkg::COL_W,
  parameter int unsigned ROW_W  = sprite_pkg::ROW_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [COL_W-1:0]  req_stride,
  input  logic [COL_W-1:0]  req_col_start,
  input  logic [COL_W-1:0]  req_cols,
  input  logic [ROW_W-1:0]  req_rows,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DATA_W-1:0] pix_index,
  output logic [COL_W-1:0]  pix_x,
  output logic [ROW_W-1:0]  pix_y,
  output logic              pix_last,
  output logic              done
);
  import sprite_pkg::*;

  localparam int unsigned EntryW = DATA_W + COL_W + ROW_W + 1;

  fetch_state_t      state_q, state_d;
  logic [COL_W-1:0]  stride_q, stride_d, cols_q, cols_d, c_q, c_d;
  logic [ROW_W-1:0]  rows_q, rows_d, r_q, r_d;
  logic [ADDR_W-1:0] row_addr_q, row_addr_d, cur_addr_q, cur_addr_d, last_addr_q;
  logic              inflight_q, inflight_d;
  logic [COL_W-1:0]  tag_x_q, tag_x_d;
  logic [ROW_W-1:0]  tag_y_q, tag_y_d;
  logic              tag_last_q, tag_last_d;
  logic              done_q, done_d;

  logic [1:0]        fifo_count;
  logic              fifo_valid;
  logic [EntryW-1:0] head;
  logic              issue, pop, push, col_wrap, last_pix, credit;

  always_comb begin
    state_d    = state_q;
    stride_d   = stride_q;
    cols_d     = cols_q;
    rows_d     = rows_q;
    c_d        = c_q;
    r_d        = r_q;
    row_addr_d = row_addr_q;
    cur_addr_d = cur_addr_q;
    tag_x_d    = tag_x_q;
    tag_y_d    = tag_y_q;
    tag_last_d = tag_last_q;
    inflight_d = 1'b0;
    done_d     = 1'b0;
    issue      = 1'b0;

    col_wrap = (c_q == cols_q - COL_W'(1));
    last_pix = col_wrap && (r_q == rows_q - ROW_W'(1));
    pop      = fifo_valid && pix_ready;
    // FIFO occupancy plus the read in flight must leave room for the new read's data.
    credit   = (({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'd3);

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          stride_d   = req_stride;
          cols_d     = req_cols;
          rows_d     = req_rows;
          c_d        = '0;
          r_d        = '0;
          row_addr_d = req_base + ADDR_W'(req_col_start);
          cur_addr_d = req_base + ADDR_W'(req_col_start);
          if ((req_cols == '0) || (req_rows == '0)) begin
            done_d = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        if (credit) begin
          issue      = 1'b1;
          inflight_d = 1'b1;
          tag_x_d    = c_q;
          tag_y_d    = r_q;
          tag_last_d = last_pix;
          if (col_wrap) begin
            c_d        = '0;
            r_d        = r_q + ROW_W'(1);
            row_addr_d = row_addr_q + ADDR_W'(stride_q);
            cur_addr_d = row_addr_q + ADDR_W'(stride_q);
            if (last_pix) state_d = DRAIN;
          end else begin
            c_d        = c_q + COL_W'(1);
            cur_addr_d = cur_addr_q + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        if (pop && head[0]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d    = IDLE;
      issue      = 1'b0;
      inflight_d = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rom_addr  = issue ? cur_addr_q : last_addr_q;
    push      = inflight_q && !abort;
    pix_valid = fifo_valid;
    {pix_index, pix_x, pix_y, pix_last} = fifo_valid ? head : '0;
    done      = done_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      stride_q    <= '0;
      cols_q      <= '0;
      rows_q      <= '0;
      c_q         <= '0;
      r_q         <= '0;
      row_addr_q  <= '0;
      cur_addr_q  <= '0;
      last_addr_q <= '0;
      inflight_q  <= 1'b0;
      tag_x_q     <= '0;
      tag_y_q     <= '0;
      tag_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stride_q    <= stride_d;
      cols_q      <= cols_d;
      rows_q      <= rows_d;
      c_q         <= c_d;
      r_q         <= r_d;
      row_addr_q  <= row_addr_d;
      cur_addr_q  <= cur_addr_d;
      last_addr_q <= rom_addr;
      inflight_q  <= inflight_d;
      tag_x_q     <= tag_x_d;
      tag_y_q     <= tag_y_d;
      tag_last_q  <= tag_last_d;
      done_q      <= done_d;
    end
  end

  pix_fifo3 #(
    .W(EntryW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (abort),
    .push     (push),
    .push_data({rom_data, tag_x_q, tag_y_q, tag_last_q}),
    .pop      (pop),
    .head     (head),
    .valid    (fifo_valid),
    .count    (fifo_count)
  );

  max_outstanding: assert property (@(posedge clk) disable iff (rst)
    (({1'b0, fifo_count} + {2'b00, inflight_q}) <= 3'd3));

endmodule

// File: tb/tb_sprite_fetch_engine.sv
// Self-checking bench: a behavioural ROM plus a window model (row*stride arithmetic)
// predicting every pixel, its tags and, at full speed, the per-cycle read address.
module tb_sprite_fetch_engine;
  import sprite_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_base = '0;
  logic [COL_W-1:0]  req_stride = '0;
  logic [COL_W-1:0]  req_col_start = '0;
  logic [COL_W-1:0]  req_cols = '0;
  logic [ROW_W-1:0]  req_rows = '0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data = '0;
  logic              pix_valid;
  logic              pix_ready = 1'b0;
  logic [DATA_W-1:0] pix_index;
  logic [COL_W-1:0]  pix_x;
  logic [ROW_W-1:0]  pix_y;
  logic              pix_last;
  logic              done;

  int errors = 0;
  int checks = 0;

  sprite_fetch_engine dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_base     (req_base),
    .req_stride   (req_stride),
    .req_col_start(req_col_start),
    .req_cols     (req_cols),
    .req_rows     (req_rows),
    .abort        (abort),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_index    (pix_index),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_last     (pix_last),
    .done         (done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] rom_fn(input logic [17:0] a);
    logic [17:0] t;
    t = a ^ (a >> 4) ^ (a >> 11);
    return t[3:0];
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  // Presents one request and follows the pixel stream to done (or to an abort at pixel abort_at).
  task automatic run_window(input int base, input int stride, input int col_start,
                            input int cols, input int rows, input int ready_pct,
                            input int abort_at, input bit full_speed,
                            output int popped, output int done_cnt,
                            output int first_addr, output int end_addr);
    pix_entry_t exp_q[$];
    int         addr_q[$];
    pix_entry_t e, got, prev;
    int         total, cyc, a;
    bit         stalled, finished;
    popped = 0; done_cnt = 0; first_addr = -1; end_addr = -1;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        a = (base + r * stride + col_start + c) & 32'h3FFFF;
        addr_q.push_back(a);
        e.index = rom_fn(18'(a));
        e.x     = 12'(c);
        e.y     = 8'(r);
        e.last  = (r == rows - 1) && (c == cols - 1);
        exp_q.push_back(e);
      end
    end
    total = cols * rows;
    @(posedge clk); #1;
    req_base = 18'(base); req_stride = 12'(stride); req_col_start = 12'(col_start);
    req_cols = 12'(cols); req_rows = 8'(rows); req_valid = 1'b1; abort = 1'b0; pix_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL req_ready_idle: got %b expected 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    stalled = 1'b0; finished = 1'b0; cyc = 0; prev = '0;
    while (!finished && cyc < total * 20 + 100) begin
      if (abort_at >= 0 && popped == abort_at && pix_valid) begin
        abort = 1'b1; pix_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        #1;
        checks++;
        if (pix_valid !== 1'b0) begin
          errors++; $display("FAIL abort_pix_valid: got %b expected 0", pix_valid);
        end
        checks++;
        if (req_ready !== 1'b1) begin
          errors++; $display("FAIL abort_to_idle: req_ready got %b expected 1", req_ready);
        end
        for (int k = 0; k < 6; k++) begin
          if (done === 1'b1) done_cnt++;
          @(posedge clk); #2;
        end
        return;
      end
      pix_ready = ($urandom_range(99) < ready_pct);
      #1;
      got = {pix_index, pix_x, pix_y, pix_last};
      if (cyc == 0) first_addr = int'(rom_addr);
      if (full_speed && cyc < total) begin
        checks++;
        if (int'(rom_addr) != addr_q[cyc]) begin
          errors++;
          $display("FAIL rom_addr_seq cycle %0d: got %0d expected %0d", cyc, rom_addr, addr_q[cyc]);
        end
      end
      if (full_speed && cyc < 2) begin
        checks++;
        if (pix_valid !== 1'b0) begin
          errors++; $display("FAIL fill_latency cycle %0d: pix_valid got %b expected 0", cyc, pix_valid);
        end
      end
      if (stalled) begin
        checks++;
        if (pix_valid !== 1'b1 || got != prev) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b head=%h expected valid=1 head=%h", pix_valid, got, prev);
        end
      end
      if (pix_valid === 1'b1 && exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_pixel: got pixel %h expected none", got);
      end
      if (done === 1'b1) begin
        done_cnt++; finished = 1'b1; end_addr = int'(rom_addr);
        checks++;
        if (popped != total) begin
          errors++; $display("FAIL done_early: popped %0d expected %0d", popped, total);
        end
        if (full_speed) begin
          checks++;
          if (cyc != total + 2) begin
            errors++; $display("FAIL throughput: done at cycle %0d expected %0d", cyc, total + 2);
          end
        end
      end
      if (pix_valid === 1'b1 && pix_ready && exp_q.size() != 0) begin
        checks++;
        if (got != exp_q[0]) begin
          errors++;
          $display("FAIL pixel %0d: got idx=%0d x=%0d y=%0d last=%b expected idx=%0d x=%0d y=%0d last=%b",
                   popped, got.index, got.x, got.y, got.last,
                   exp_q[0].index, exp_q[0].x, exp_q[0].y, exp_q[0].last);
        end
        void'(exp_q.pop_front());
        popped++;
      end
      stalled = pix_valid && !pix_ready;
      prev = got;
      @(posedge clk); #1;
      cyc++;
    end
    if (!finished) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done after %0d cycles, popped %0d of %0d", cyc, popped, total);
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      if (done === 1'b1) done_cnt++;
      @(posedge clk); #2;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if (req_ready !== 1'b1 || pix_valid !== 1'b0 || done !== 1'b0 || rom_addr !== '0 ||
        pix_index !== '0 || pix_x !== '0 || pix_y !== '0 || pix_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got ready=%b valid=%b done=%b addr=%0d idx=%0d x=%0d y=%0d last=%b expected 1 0 0 0 0 0 0 0",
               req_ready, pix_valid, done, rom_addr, pix_index, pix_x, pix_y, pix_last);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_cloud();
    int popped, dn, fa, ea;
    run_window(CLOUD_BASE, CLOUD_W, 0, CLOUD_W, CLOUD_H, 100, -1, 1'b1, popped, dn, fa, ea);
    checks++;
    if (popped != 2484) begin errors++; $display("FAIL cloud_count: got %0d expected 2484", popped); end
    checks++;
    if (fa != 44420) begin errors++; $display("FAIL cloud_first_addr: got %0d expected 44420", fa); end
    checks++;
    if (ea != 46903) begin errors++; $display("FAIL cloud_last_addr: got %0d expected 46903", ea); end
    checks++;
    if (dn != 1) begin errors++; $display("FAIL cloud_done_once: got %0d expected 1", dn); end
  endtask

  task automatic test_horizon_scroll();
    int popped, dn, fa, ea;
    run_window(HORIZON_BASE, HORIZON_W, 2000, 400, HORIZON_H, 100, -1, 1'b1, popped, dn, fa, ea);
    checks++;
    if (popped != 9600) begin errors++; $display("FAIL horizon_count: got %0d expected 9600", popped); end
    checks++;
    if (fa != 87015) begin errors++; $display("FAIL horizon_first_addr: got %0d expected 87015", fa); end
    checks++;
    if (dn != 1) begin errors++; $display("FAIL horizon_done_once: got %0d expected 1", dn); end
  endtask

  task automatic test_backpressure();
    int popped, dn, fa, ea;
    run_window(CLOUD_BASE, CLOUD_W, 0, CLOUD_W, CLOUD_H, 50, -1, 1'b0, popped, dn, fa, ea);
    checks++;
    if (popped != 2484) begin errors++; $display("FAIL bp_count: got %0d expected 2484", popped); end
    checks++;
    if (dn != 1) begin errors++; $display("FAIL bp_done_once: got %0d expected 1", dn); end
  endtask

  task automatic test_zero_size(input int cols, input int rows);
    logic [ADDR_W-1:0] addr_before;
    int dn;
    dn = 0;
    @(posedge clk); #1;
    addr_before = rom_addr;
    req_base = 18'(RUN1_BASE); req_stride = 12'(RUN1_W); req_col_start = '0;
    req_cols = 12'(cols); req_rows = 8'(rows); req_valid = 1'b1; pix_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (done === 1'b1) dn++;
      checks++;
      if (pix_valid !== 1'b0 || rom_addr !== addr_before) begin
        errors++;
        $display("FAIL zero_no_activity: got valid=%b addr=%0d expected valid=0 addr=%0d",
                 pix_valid, rom_addr, addr_before);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (dn != 1) begin errors++; $display("FAIL zero_done: got %0d pulses expected 1", dn); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_abort();
    int popped, dn, fa, ea;
    run_window(RUN1_BASE, RUN1_W, 0, RUN1_W, RUN1_H, 70, 99, 1'b0, popped, dn, fa, ea);
    checks++;
    if (popped != 99) begin errors++; $display("FAIL abort_point: got %0d expected 99", popped); end
    checks++;
    if (dn != 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", dn); end
    run_window(NUM0_BASE, NUM0_W, 0, NUM0_W, NUM0_H, 60, -1, 1'b0, popped, dn, fa, ea);
    checks++;
    if (popped != 378) begin errors++; $display("FAIL num0_count: got %0d expected 378", popped); end
    checks++;
    if (dn != 1) begin errors++; $display("FAIL num0_done_once: got %0d expected 1", dn); end
  endtask

  task automatic test_async_reset();
    int dn;
    dn = 0;
    @(posedge clk); #1;
    req_base = 18'(HORIZON_BASE); req_stride = 12'(HORIZON_W); req_col_start = 12'd100;
    req_cols = 12'd300; req_rows = 8'd10; req_valid = 1'b1; pix_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (40) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (pix_valid !== 1'b0 || rom_addr !== '0 || pix_index !== '0 || pix_x !== '0 ||
        pix_y !== '0 || pix_last !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got valid=%b addr=%0d idx=%0d x=%0d y=%0d last=%b done=%b ready=%b expected zeros, ready=1",
               pix_valid, rom_addr, pix_index, pix_x, pix_y, pix_last, done, req_ready);
    end
    repeat (2) @(posedge clk);
    #4;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #2;
      if (done === 1'b1) dn++;
      checks++;
      if (pix_valid !== 1'b0) begin
        errors++; $display("FAIL post_reset_idle: pix_valid got %b expected 0", pix_valid);
      end
    end
    checks++;
    if (dn != 0) begin errors++; $display("FAIL post_reset_done: got %0d expected 0", dn); end
  endtask

  task automatic test_random_windows();
    int popped, dn, fa, ea, base, stride, cs, cols, rows, pct;
    for (int t = 0; t < 6; t++) begin
      base   = int'($urandom_range(262143, 0));
      stride = int'($urandom_range(300, 1));
      cs     = int'($urandom_range(200, 0));
      cols   = int'($urandom_range(20, 1));
      rows   = int'($urandom_range(6, 1));
      pct    = (t % 2 == 0) ? 100 : int'($urandom_range(90, 20));
      run_window(base, stride, cs, cols, rows, pct, -1, pct == 100, popped, dn, fa, ea);
      checks++;
      if (popped != cols * rows || dn != 1) begin
        errors++;
        $display("FAIL random_window %0d: got popped=%0d done=%0d expected popped=%0d done=1",
                 t, popped, dn, cols * rows);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cloud();
    test_horizon_scroll();
    test_backpressure();
    test_zero_size(0, 5);
    test_zero_size(7, 0);
    test_abort();
    test_async_reset();
    test_random_windows();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
